// File: rtl/phase_scan_ctrl.sv
// Phase-search scan sequencer: loads the step coefficient, triggers the angle generator,
// steps through SEARCH_TIMES sweeps and keeps the sweep with the largest FFT magnitude.
module phase_scan_ctrl #(
    parameter int SEARCH_TIMES = 3600,
    parameter int CNT_W        = 12,
    parameter int MAG_W        = 32,
    parameter int TIMEOUT      = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [18:0]      cfg_coef,
    input  logic [8:0]       cfg_cap_num,
    output logic [18:0]      valid_coef,
    output logic             coef_valid,
    output logic             trig_search,
    output logic [8:0]       cap_data_number,
    input  logic             angle_valid,
    input  logic             fft_end,
    input  logic [MAG_W-1:0] fft_mag,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] sweep_idx,
    output logic [CNT_W-1:0] best_idx,
    output logic [MAG_W-1:0] best_mag
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_ONE     = WD_W'(1);
    localparam logic [CNT_W-1:0] LAST_SWEEP = CNT_W'(SEARCH_TIMES - 1);
    localparam logic [CNT_W-1:0] SWEEP_ONE  = CNT_W'(1);
    localparam logic [8:0]       SMP_ONE    = 9'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TRIG, S_CAPTURE, S_WAIT_FFT, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [18:0]      coef_q, coef_d;
    logic [8:0]       cap_num_q, cap_num_d;
    logic [8:0]       smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0] sweep_q, sweep_d;
    logic [CNT_W-1:0] best_idx_q, best_idx_d;
    logic [MAG_W-1:0] best_mag_q, best_mag_d;
    logic [1:0]       err_q, err_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            coef_q     <= '0;
            cap_num_q  <= '0;
            smp_cnt_q  <= '0;
            sweep_q    <= '0;
            best_idx_q <= '0;
            best_mag_q <= '0;
            err_q      <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            coef_q     <= coef_d;
            cap_num_q  <= cap_num_d;
            smp_cnt_q  <= smp_cnt_d;
            sweep_q    <= sweep_d;
            best_idx_q <= best_idx_d;
            best_mag_q <= best_mag_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        coef_d     = coef_q;
        cap_num_d  = cap_num_q;
        smp_cnt_d  = smp_cnt_q;
        sweep_d    = sweep_q;
        best_idx_d = best_idx_q;
        best_mag_d = best_mag_q;
        err_d      = err_q;
        wdog_d     = wdog_q;

        // abort overrides every other event, including an fft_end in the same cycle
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && cfg_cap_num != '0) begin
                        coef_d     = cfg_coef;
                        cap_num_d  = cfg_cap_num;
                        err_d      = '0;
                        best_idx_d = '0;
                        best_mag_d = '0;
                        sweep_d    = '0;
                        state_d    = S_LOAD;
                    end
                end
                S_LOAD: state_d = S_TRIG;
                S_TRIG: begin
                    smp_cnt_d = '0;
                    wdog_d    = '0;
                    state_d   = S_CAPTURE;
                end
                S_CAPTURE: begin
                    wdog_d = wdog_q + WD_ONE;
                    if (fft_end) begin
                        err_d[1] = 1'b1;
                        state_d  = S_ERR;
                    end else if (angle_valid) begin
                        wdog_d    = '0;
                        smp_cnt_d = smp_cnt_q + SMP_ONE;
                        if (smp_cnt_q + SMP_ONE == cap_num_q) begin
                            state_d = S_WAIT_FFT;
                        end
                    end else if (wdog_q == WD_LIMIT) begin
                        err_d[0] = 1'b1;
                        state_d  = S_ERR;
                    end
                end
                S_WAIT_FFT: begin
                    wdog_d = wdog_q + WD_ONE;
                    if (fft_end) begin
                        wdog_d = '0;
                        // strict compare keeps the earliest sweep on ties
                        if (sweep_q == '0 || fft_mag > best_mag_q) begin
                            best_mag_d = fft_mag;
                            best_idx_d = sweep_q;
                        end
                        if (sweep_q == LAST_SWEEP) begin
                            state_d = S_DONE;
                        end else begin
                            sweep_d   = sweep_q + SWEEP_ONE;
                            smp_cnt_d = '0;
                            state_d   = S_CAPTURE;
                        end
                    end else if (wdog_q == WD_LIMIT) begin
                        err_d[0] = 1'b1;
                        state_d  = S_ERR;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign valid_coef      = coef_q;
    assign coef_valid      = (state_q == S_LOAD);
    assign trig_search     = (state_q == S_TRIG);
    assign cap_data_number = cap_num_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign err             = err_q;
    assign sweep_idx       = sweep_q;
    assign best_idx        = best_idx_q;
    assign best_mag        = best_mag_q;

endmodule

// File: tb/tb_phase_scan_ctrl.sv
// Bench for phase_scan_ctrl: table of full scans checked through a done-pulse scoreboard,
// plus directed sequences for errors, abort and asynchronous reset.
module tb_phase_scan_ctrl;

    localparam int SEARCH_TIMES = 4;
    localparam int CNT_W        = 12;
    localparam int MAG_W        = 32;
    localparam int TIMEOUT      = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, abort;
    logic [18:0]      cfg_coef;
    logic [8:0]       cfg_cap_num;
    logic [18:0]      valid_coef;
    logic             coef_valid, trig_search;
    logic [8:0]       cap_data_number;
    logic             angle_valid, fft_end;
    logic [MAG_W-1:0] fft_mag;
    logic             busy, done;
    logic [1:0]       err;
    logic [CNT_W-1:0] sweep_idx, best_idx;
    logic [MAG_W-1:0] best_mag;

    phase_scan_ctrl #(
        .SEARCH_TIMES(SEARCH_TIMES), .CNT_W(CNT_W), .MAG_W(MAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_coef(cfg_coef), .cfg_cap_num(cfg_cap_num),
        .valid_coef(valid_coef), .coef_valid(coef_valid), .trig_search(trig_search),
        .cap_data_number(cap_data_number), .angle_valid(angle_valid), .fft_end(fft_end),
        .fft_mag(fft_mag), .busy(busy), .done(done), .err(err),
        .sweep_idx(sweep_idx), .best_idx(best_idx), .best_mag(best_mag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0]            coef;
        logic [8:0]             cap;
        logic [3:0][MAG_W-1:0]  mags;
        int                     extra;
        logic [CNT_W-1:0]       exp_idx;
        logic [MAG_W-1:0]       exp_mag;
    } vec_t;

    typedef struct {
        logic [CNT_W-1:0] idx;
        logic [MAG_W-1:0] mag;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [18:0] c, input logic [8:0] n,
                                input logic [MAG_W-1:0] m0, m1, m2, m3, input int x,
                                input logic [CNT_W-1:0] ei, input logic [MAG_W-1:0] em);
        vec_t v;
        v.coef = c; v.cap = n; v.extra = x; v.exp_idx = ei; v.exp_mag = em;
        v.mags[0] = m0; v.mags[1] = m1; v.mags[2] = m2; v.mags[3] = m3;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_best_idx", 64'(best_idx), 64'(e.idx));
                chk("sb_best_mag", 64'(best_mag), 64'(e.mag));
                chk("sb_err", 64'(err), 64'd0);
            end
        end
    end

    task automatic prologue(input logic [18:0] c, input logic [8:0] n);
        cfg_coef = c; cfg_cap_num = n; start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_coef_valid", 64'(coef_valid), 64'd1);
        chk("load_trig", 64'(trig_search), 64'd0);
        chk("load_valid_coef", 64'(valid_coef), 64'(c));
        chk("load_err_cleared", 64'(err), 64'd0);
        tick();
        chk("trig_pulse", 64'(trig_search), 64'd1);
        chk("trig_coef_valid", 64'(coef_valid), 64'd0);
        tick();
        chk("cap_trig_low", 64'(trig_search), 64'd0);
        chk("cap_number", 64'(cap_data_number), 64'(n));
    endtask

    task automatic angles(input int n);
        for (int i = 0; i < n; i++) begin
            angle_valid = 1'b1;
            tick();
            angle_valid = 1'b0;
        end
    endtask

    task automatic sweep(input int cap, input int extra, input logic [MAG_W-1:0] m);
        angles(cap + extra);
        fft_end = 1'b1; fft_mag = m;
        tick();
        fft_end = 1'b0;
    endtask

    task automatic run_scan(input vec_t v);
        exp_t e;
        e.idx = v.exp_idx; e.mag = v.exp_mag;
        sb_q.push_back(e);
        prologue(v.coef, v.cap);
        for (int s = 0; s < SEARCH_TIMES; s++) begin
            chk("sweep_idx", 64'(sweep_idx), 64'(s));
            sweep(int'(v.cap), v.extra, v.mags[s]);
        end
        chk("done_busy", 64'(busy), 64'd1);
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_coef = '0; cfg_cap_num = '0;
        angle_valid = 1'b0; fft_end = 1'b0; fft_mag = '0;

        vecs[0] = mk(19'h01234, 9'd3, 32'd10, 32'd50, 32'd50, 32'd20, 0, 12'd1, 32'd50);
        vecs[1] = mk(19'h7FFFF, 9'd1, 32'd5, 32'd5, 32'd5, 32'd5, 1, 12'd0, 32'd5);
        vecs[2] = mk(19'h00001, 9'd2, 32'd1, 32'd2, 32'd3, 32'd4, 2, 12'd3, 32'd4);
        vecs[3] = mk(19'h2AAAA, 9'd3, 32'd0, 32'd0, 32'd0, 32'd0, 0, 12'd0, 32'd0);
        vecs[4] = mk(19'h55555, 9'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd8, 0, 12'd0, 32'hFFFF_FFFF);
        vecs[5] = mk(19'h00F0F, 9'd4, 32'd3, 32'd9, 32'd2, 32'd9, 1, 12'd1, 32'd9);

        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outputs", {valid_coef, coef_valid, trig_search, cap_data_number, done, err},
            64'd0);
        chk("rst_idx", {sweep_idx, best_idx, best_mag}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) run_scan(vecs[i]);

        // start with zero samples per sweep is ignored
        cfg_coef = 19'h0ABCD; cfg_cap_num = 9'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_cap_busy", 64'(busy), 64'd0);
        chk("zero_cap_coef_valid", 64'(coef_valid), 64'd0);
        tick();
        chk("zero_cap_trig", 64'(trig_search), 64'd0);
        chk("zero_cap_busy2", 64'(busy), 64'd0);

        // fft_end after 1 of 3 angle samples
        prologue(19'h01234, 9'd3);
        angles(1);
        fft_end = 1'b1; fft_mag = 32'd99;
        tick();
        fft_end = 1'b0;
        chk("seq_err_val", 64'(err), 64'd2);
        chk("seq_err_busy", 64'(busy), 64'd1);
        tick();
        chk("seq_err_idle", 64'(busy), 64'd0);
        chk("seq_err_sticky", 64'(err), 64'd2);

        // angle_valid and fft_end together on the completing strobe: seq_err wins
        prologue(19'h01234, 9'd3);
        angles(2);
        angle_valid = 1'b1; fft_end = 1'b1;
        tick();
        angle_valid = 1'b0; fft_end = 1'b0;
        chk("simul_err", 64'(err), 64'd2);
        tick();
        chk("simul_idle", 64'(busy), 64'd0);

        // watchdog in WAIT_FFT fires after exactly TIMEOUT idle cycles
        prologue(19'h00077, 9'd2);
        angles(2);
        repeat (TIMEOUT - 1) tick();
        chk("wdog_not_yet", 64'(err), 64'd0);
        chk("wdog_still_busy", 64'(busy), 64'd1);
        tick();
        chk("wdog_err", 64'(err), 64'd1);
        tick();
        chk("wdog_idle", 64'(busy), 64'd0);
        chk("wdog_sticky", 64'(err), 64'd1);
        run_scan(vecs[0]);

        // abort during sweep 2, coincident with fft_end
        prologue(19'h00321, 9'd3);
        sweep(3, 0, 32'd10);
        sweep(3, 0, 32'd80);
        angles(3);
        fft_end = 1'b1; fft_mag = 32'd999; abort = 1'b1;
        tick();
        fft_end = 1'b0; abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_best_mag", 64'(best_mag), 64'd80);
        chk("abort_best_idx", 64'(best_idx), 64'd1);
        chk("abort_err", 64'(err), 64'd0);
        tick();
        chk("abort_stays_idle", 64'(busy), 64'd0);
        run_scan(mk(19'h00321, 9'd2, 32'd1, 32'd2, 32'd3, 32'd1, 0, 12'd2, 32'd3));

        // asynchronous reset in the middle of CAPTURE
        prologue(19'h1F00F, 9'd2);
        sweep(2, 0, 32'd77);
        angles(1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_outputs", {valid_coef, coef_valid, trig_search, cap_data_number, done, err},
            64'd0);
        chk("arst_idx", {sweep_idx, best_idx, best_mag}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_scan(vecs[5]);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_scan_ctrl.md
Name: phase_scan_ctrl

Overview:
- Sequences one complete phase-search scan in the CO2 dispersion interferometer back end.
- Loads the phase-step coefficient into the angle generator and fires the search trigger.
- Per sweep: counts generated angle samples, then waits for the FFT end strobe, for SEARCH_TIMES sweeps.
- Tracks the sweep with the largest FFT magnitude and reports it to the host side on completion.

Parameters:
SEARCH_TIMES, 3600, number of sweeps per scan (theta steps)
CNT_W, 12, width of sweep counter/index; must hold SEARCH_TIMES-1
MAG_W, 32, width of FFT magnitude input
TIMEOUT, 65535, max idle cycles between progress events before error

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  single-cycle scan request
abort  in  1  single-cycle scan cancel
cfg_coef  in  19  phase-step coefficient for this scan
cfg_cap_num  in  9  angle samples per sweep
valid_coef  out  19  coefficient to angle generator
coef_valid  out  1  one-cycle load strobe for valid_coef
trig_search  out  1  one-cycle scan trigger to angle generator
cap_data_number  out  9  samples per sweep, held stable while busy
angle_valid  in  1  angle sample strobe from angle generator
fft_end  in  1  one-cycle FFT-complete strobe, ends a sweep
fft_mag  in  MAG_W  FFT peak magnitude, valid with fft_end
busy  out  1  scan in progress
done  out  1  one-cycle scan-complete pulse
err  out  2  sticky {seq_err, timeout_err}; cleared on accepted start
sweep_idx  out  CNT_W  current sweep number
best_idx  out  CNT_W  sweep index of max fft_mag
best_mag  out  MAG_W  max fft_mag of last scan

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- States: IDLE, LOAD, TRIG, CAPTURE, WAIT_FFT, DONE, ERR.
- IDLE:
  - start with cfg_cap_num!=0: latch cfg_coef and cfg_cap_num, clear err/best/sweep, go to LOAD.
  - start with cfg_cap_num==0: ignored, state unchanged.
- LOAD: coef_valid=1 for exactly one cycle, valid_coef=latched coef (held after); go to TRIG.
- TRIG: trig_search=1 for exactly one cycle; go to CAPTURE with sample count cleared.
  - Latency: start at cycle N gives coef_valid at N+1 and trig_search at N+2.
- CAPTURE:
  - Count angle_valid; on the strobe making count==cap_data_number, go to WAIT_FFT.
  - fft_end while in CAPTURE: set seq_err, go to ERR.
- WAIT_FFT:
  - Extra angle_valid ignored.
  - On fft_end, update peak: if sweep_idx==0 or fft_mag>best_mag (unsigned, strict), load best_mag=fft_mag and best_idx=sweep_idx. Ties keep the earlier index.
  - If sweep_idx==SEARCH_TIMES-1, go to DONE.
  - Otherwise sweep_idx+1, clear sample count, go to CAPTURE with no new trig. The angle generator restarts on fft_end itself.
- DONE: done=1 one cycle; go to IDLE.
- ERR: one cycle, then IDLE; no done pulse; err retained.
- busy=1 in every state except IDLE.
- Watchdog:
  - Counter active in CAPTURE and WAIT_FFT only.
  - Cleared on state entry and on each counted angle_valid or fft_end.
  - Reaching TIMEOUT sets timeout_err and goes to ERR.
- abort (any non-IDLE state): next state IDLE, no done, err unchanged, best_* holds partial-scan values. abort has priority over all events in the same cycle.
- start while busy: ignored.
- Simultaneous angle_valid and fft_end in CAPTURE: seq_err wins.
- sweep_idx never wraps; the DONE check precedes increment.
- Async reset mid-scan: immediate return to reset values. Any coef/trig pulse in flight is truncated.

Test Plan:
- SEARCH_TIMES=4, cfg_cap_num=3, cfg_coef=0x1234; start; per sweep 3 angle_valid then fft_end with mags 10,50,50,20 -> coef_valid at +1, trig_search at +2 (both single), done once after 4th fft_end, best_idx=1, best_mag=50, err=0.
- Start with cfg_cap_num=0 -> busy stays 0, no coef_valid/trig_search.
- fft_end after only 1 of 3 angle_valid -> err=2'b10, busy drops 2 cycles later, no done.
- TIMEOUT=16, stop stimulus in WAIT_FFT -> err=2'b01 after 16 cycles, return to IDLE; next valid start clears err.
- abort during sweep 2 -> busy 0 next cycle, no done; restart completes normally with fresh best values.
- rst_n low during CAPTURE -> all outputs 0 immediately; start after release runs a full scan correctly.
